// File: rtl/clock_gen_pkg.sv
// NES system timing constants shared by the clock generator and future timing blocks
// (APU/audio).
// Holds the board and NTSC PPU frequencies, the CPU/PPU ratio and the NCO increment
// derived from them.
package clock_gen_pkg;

  localparam longint unsigned SYS_CLK_HZ   = 100_000_000;
  localparam longint unsigned PPU_CLK_HZ   = 5_369_318;
  localparam int unsigned     NTSC_CPU_DIV = 3;
  localparam int unsigned     NES_ACC_W    = 24;

  // round(f_out / f_ref * 2^acc_w), evaluated in integer arithmetic at elaboration.
  function automatic int unsigned nco_inc(input longint unsigned f_out,
                                          input longint unsigned f_ref,
                                          input int unsigned     acc_w);
    return 32'(((f_out << acc_w) + (f_ref >> 1)) / f_ref);
  endfunction

  // Evaluates to 900822 for the NTSC PPU from 100 MHz.
  localparam int unsigned NES_PPU_INC = nco_inc(PPU_CLK_HZ, SYS_CLK_HZ, NES_ACC_W);

endpackage

// File: rtl/clock_gen_if.sv
// Timing outputs of the NES clock generator.
//   o_25_mhz : clk/4 square wave (pixel clock source)
//   o_ppu    : one-cycle PPU clock-enable strobe
//   o_cpu    : one-cycle CPU clock-enable strobe, coincident with every Nth o_ppu
// master = the generator, slave = the consumers (video scan-out, PPU, CPU).
interface clock_gen_if;

  logic o_25_mhz;
  logic o_ppu;
  logic o_cpu;

  modport master (
    output o_25_mhz,
    output o_ppu,
    output o_cpu
  );

  modport slave (
    input o_25_mhz,
    input o_ppu,
    input o_cpu
  );

endinterface

// File: rtl/clock_gen_phase_nco.sv
// Phase-accumulator NCO: adds INC to an ACC_W-bit accumulator every clk and reports
// the carry out of that addition. Mean carry rate is f_clk * INC / 2^ACC_W.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, clears the accumulator
//   carry_o : carry of the addition being committed on the next rising edge
// carry_o depends only on the accumulator register, so the caller decides where
// to register it.
module clock_gen_phase_nco #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned INC   = 900822
) (
  input  logic clk,
  input  logic rst_n,
  output logic carry_o
);

  if (ACC_W < 1) begin : g_bad_width
    $error("clock_gen_phase_nco: ACC_W must be at least 1");
  end
  if ((ACC_W < 32) && (INC >= (32'd1 << ACC_W))) begin : g_bad_inc
    $error("clock_gen_phase_nco: INC must be below 2^ACC_W");
  end

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(INC);
  assign carry_o = sum[ACC_W];

  // Modular wrap: the carry is reported, the accumulator keeps the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/clock_gen.sv
// NES clock generator. From the 100 MHz board clock derives:
//   - a registered clk/4 square wave for the 25 MHz VGA pixel clock,
//   - a PPU clock-enable strobe at a mean 5.369318 MHz (NCO carry),
//   - a CPU clock-enable strobe on every CPU_DIV-th PPU strobe.
// Strobes are single-cycle enables in the clk domain, not clocks.
// Ports:
//   clk     : 100 MHz system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   strobes : master side of clock_gen_if (o_25_mhz, o_ppu, o_cpu), all registered
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int unsigned ACC_W   = NES_ACC_W,
  parameter int unsigned PPU_INC = NES_PPU_INC,
  parameter int unsigned CPU_DIV = NTSC_CPU_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  clock_gen_if.master strobes
);

  if (CPU_DIV < 1) begin : g_bad_div
    $error("clock_gen: CPU_DIV must be at least 1");
  end

  localparam int unsigned     CntW    = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [CntW-1:0] CpuLast = CntW'(CPU_DIV - 1);

  logic [1:0]      div_cnt_q;
  logic            div_q;
  logic            ppu_q;
  logic            cpu_q;
  logic [CntW-1:0] cpu_cnt_q;
  logic [CntW-1:0] cpu_cnt_d;
  logic            cpu_d;
  logic            ppu_carry;

  clock_gen_phase_nco #(
    .ACC_W (ACC_W),
    .INC   (PPU_INC)
  ) u_ppu_nco (
    .clk     (clk),
    .rst_n   (rst_n),
    .carry_o (ppu_carry)
  );

  // The CPU counter only moves on a PPU carry; the wrap marks the CPU strobe so it
  // lands in the same cycle as the matching PPU strobe.
  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    cpu_d     = 1'b0;
    if (ppu_carry) begin
      if (cpu_cnt_q == CpuLast) begin
        cpu_cnt_d = '0;
        cpu_d     = 1'b1;
      end else begin
        cpu_cnt_d = cpu_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= 2'd0;
      div_q     <= 1'b0;
      ppu_q     <= 1'b0;
      cpu_cnt_q <= '0;
      cpu_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_q + 2'd1;
      // Registered copy of bit 1 gives two low, two high cycles after release.
      div_q     <= div_cnt_q[1];
      ppu_q     <= ppu_carry;
      cpu_cnt_q <= cpu_cnt_d;
      cpu_q     <= cpu_d;
    end
  end

  assign strobes.o_25_mhz = div_q;
  assign strobes.o_ppu    = ppu_q;
  assign strobes.o_cpu    = cpu_q;

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: default NTSC instance plus a PPU_INC=0 instance on the same
// clock and reset, compared cycle by cycle against an arithmetic reference.
module tb_clock_gen;

  localparam longint unsigned RefInc = 900822;
  localparam int unsigned     RefAccW = 24;
  localparam longint unsigned RefCpuDiv = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  clock_gen_if dut_if ();
  clock_gen_if zero_if ();

  clock_gen u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobes (dut_if)
  );

  clock_gen #(
    .PPU_INC (0)
  ) u_dut_zero (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobes (zero_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {o_25_mhz, o_ppu, o_cpu} after the k-th rising edge since release
  // (k=0: in reset). PPU strobe whenever floor(k*inc/2^W) steps; CPU strobe when
  // that PPU strobe index is a multiple of the divider.
  function automatic logic [2:0] exp_out(input longint unsigned k, input longint unsigned inc);
    longint unsigned n_now, n_prev;
    logic o25, ppu, cpu;
    if (k == 0) return 3'b000;
    o25   = (((k - 1) / 2) % 2) == 1;
    n_now = (k * inc) >> RefAccW;
    n_prev = ((k - 1) * inc) >> RefAccW;
    ppu   = (n_now != n_prev);
    cpu   = ppu && ((n_now % RefCpuDiv) == 0);
    return {o25, ppu, cpu};
  endfunction

  task automatic check_cycle(input longint unsigned k, input string ph);
    logic [2:0] e, ez;
    e  = exp_out(k, RefInc);
    ez = exp_out(k, 0);
    check({ph, ".o25"}, dut_if.o_25_mhz, e[2]);
    check({ph, ".ppu"}, dut_if.o_ppu, e[1]);
    check({ph, ".cpu"}, dut_if.o_cpu, e[0]);
    check({ph, ".z_o25"}, zero_if.o_25_mhz, ez[2]);
    check({ph, ".z_ppu"}, zero_if.o_ppu, ez[1]);
    check({ph, ".z_cpu"}, zero_if.o_cpu, ez[0]);
  endtask

  // Called 1 time unit after a rising edge; releases somewhere mid-cycle.
  task automatic release_mid();
    #($urandom_range(2, 7));
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned n_ppu, n_cpu, first_ppu_k, last_ppu_k, gap_min, gap_max;
    int unsigned first_cpu_idx, orphans;
    longint unsigned k;

    n_ppu = 0; n_cpu = 0; first_ppu_k = 0; last_ppu_k = 0;
    gap_min = 1000; gap_max = 0; first_cpu_idx = 0; orphans = 0;

    // Held in reset: everything stays low while the clock runs.
    rst_n = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      check_cycle(0, "rst");
    end

    // Long run from release.
    release_mid();
    for (int i = 1; i <= 10000; i++) begin
      @(posedge clk);
      #1;
      check_cycle(longint'(i), "run");
      if (dut_if.o_ppu === 1'b1) begin
        n_ppu++;
        if (n_ppu == 1) begin
          first_ppu_k = i;
        end else begin
          if (i - last_ppu_k < gap_min) gap_min = i - last_ppu_k;
          if (i - last_ppu_k > gap_max) gap_max = i - last_ppu_k;
        end
        last_ppu_k = i;
      end
      if (dut_if.o_cpu === 1'b1) begin
        n_cpu++;
        if (dut_if.o_ppu !== 1'b1) orphans++;
        if (n_cpu == 1) first_cpu_idx = n_ppu;
      end
    end
    check("ppu_count_in_536_537", (n_ppu >= 536) && (n_ppu <= 537), 1);
    check("first_ppu_cycle", first_ppu_k, 19);
    check("ppu_gap_min", gap_min, 18);
    check("ppu_gap_max", gap_max, 19);
    check("cpu_count", n_cpu, n_ppu / 3);
    check("cpu_without_ppu", orphans, 0);
    check("first_cpu_ppu_index", first_cpu_idx, 3);

    // Mid-operation resets at random points, then deterministic restart.
    k = 10000;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < int'($urandom_range(0, 300)); j++) begin
        @(posedge clk);
        #1;
        k++;
        check_cycle(k, "pre");
      end
      #($urandom_range(1, 6));
      rst_n = 1'b0;
      #1;
      check_cycle(0, "async");
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
        check_cycle(0, "hold");
      end
      release_mid();
      k = 0;
      for (int j = 0; j < 60; j++) begin
        @(posedge clk);
        #1;
        k++;
        check_cycle(k, "restart");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
